nes_pad_target: RTL and testbench
=================================

# nes_pad_target

Two-wire responder that emulates a NES joypad on the bridge bus, i.e. the target end of the protocol driven by `nes_bridge`. It recognises START/STOP, matches a 7-bit address with the read bit set, ACKs, then shifts out a snapshot of the 8 button lines MSB first. It serves as the bench/loopback partner for `nes_bridge`, and as a joypad source when one board feeds another.

## Interface
- `ADDRESS`, 7'h52, 7-bit target address.
- `SYNC_STAGES`, 2, synchronizer depth on `scl_in`/`sda_in` (≥2).
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `scl_in`  input  1  bus clock from initiator (asynchronous).
- `sda_in`  input  1  bus data as seen on the wire (asynchronous).
- `sda_out`  output  1  open-drain drive: 0 = pull low, 1 = release.
- `joypad`  input  8  button lines, wire polarity (0 = pressed), bit order = `nes_bridge` output order.
- `busy`  output  1  high from START with address match until STOP/restart/abort.
- `byte_done`  output  1  one-cycle pulse when a data byte's acknowledge bit is sampled.
- `acked`  output  1  value of last master acknowledge (1 = ACK, i.e. sda low); valid with `byte_done`, held until next.

## Operation
- Inputs pass through `SYNC_STAGES` flops; one extra register holds the previous synced value for edge detection. All events below refer to synced signals.
- START: sda 1→0 while scl = 1. STOP: sda 0→1 while scl = 1. Both take priority over any state.
- Bits sampled on scl rising; `sda_out` changed only on scl falling (or on START/STOP/reset release).
- States:
  - IDLE: `sda_out`=1, `busy`=0. START → ADDR, bit_cnt=0.
  - ADDR: shift sda on 8 rising edges into addr_sr. After 8th: if addr_sr == {ADDRESS,1} → ADDR_ACK pending; else → WAIT_STOP. Write bit (0) to own address also → WAIT_STOP (no ACK).
  - ADDR_ACK: on next scl fall drive `sda_out`=0, set `busy`=1; hold through the following rise; on the next fall load tx_sr ← `joypad`, drive `sda_out` = tx_sr[7] → TX, bit_cnt=0.
  - TX: each scl fall after the first bit drives next bit (MSB first). After 8 rises, next fall releases `sda_out`=1 → MST_ACK.
  - MST_ACK: on rise sample sda: pulse `byte_done`, `acked` = ~sda. ACK → on next fall reload tx_sr ← `joypad` (fresh snapshot), drive bit 7, → TX. NACK → WAIT_STOP.
  - WAIT_STOP: `sda_out`=1; leaves only on START (→ ADDR) or STOP (→ IDLE).
- Repeated START in any state: release `sda_out`, clear bit_cnt, → ADDR; `busy` falls until the new address matches.
- STOP in any state: `sda_out`=1, `busy`=0, → IDLE on the detecting cycle.
- bit_cnt is 4 bits, counts 0..8, never wraps; counting stops once bit_cnt reaches 8.
- Snapshot: `joypad` is captured only at byte load. Changes on `joypad` mid-byte do not affect the bits already being sent.

## Timing
- Reset (rst high at clk edge): state IDLE, `sda_out`=1, `busy`=0, `byte_done`=0, `acked`=0, shift regs 0, sync flops 1 (bus idle).
- Edge latency: a pin transition is detected `SYNC_STAGES`+1 clk edges after it occurs. `sda_out` and state update on that same edge (latency 3 clk at default).
- Minimum scl high/low time: 5 clk. `nes_bridge` at `SCL_PERIOD`=20 gives 10 clk per half, which meets this.
- `sda_out` never changes while synced scl = 1, except on START/STOP detection and reset.
- `byte_done` is high exactly one cycle, on the detection edge of the 9th scl rise of a data byte.
- Reset mid-byte: next cycle `sda_out`=1. The bus recovers at the next START.

## Test plan
- ADDRESS=7'h52, `joypad`=8'hA5, master sends START, 0xA5 addr byte ({52,1}), NACKs after one byte, STOP → ACK low on 9th clock; bits read 1,0,1,0,0,1,0,1; `byte_done` pulses once with `acked`=0; `busy` returns 0 three clk after STOP.
- Address 0x53<<1|1 (mismatch) → `sda_out` stays 1 for the whole transaction; `busy` never rises; no `byte_done`.
- Two-byte read with master ACK, `joypad` changes 8'hFF→8'h00 during byte 1 → byte 1 = 0xFF, byte 2 = 0x00; `byte_done` pulses twice (`acked` 1 then 0).
- Write request {52,0} → no ACK; target ignores data until STOP, then a read transaction succeeds normally.
- Repeated START after bit 4 of a data byte, followed by a valid read → `sda_out` releases within 3 clk of START; new address ACKed; fresh snapshot sent.
- Assert `rst` for 1 cycle while `sda_out`=0 (ACK phase) → `sda_out`=1 and `busy`=0 on the next edge; no `byte_done`; next START/read completes correctly.

Source files
------------

// File: rtl/nes_pad_target.sv
// NES joypad emulator on the two-wire bridge bus: answers reads at ADDRESS
// with a fresh snapshot of the button lines per byte, MSB first.
module nes_pad_target #(
  parameter logic [6:0]  ADDRESS     = 7'h52,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] joypad,
  output logic       busy,
  output logic       byte_done,
  output logic       acked
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    TX,
    MST_ACK,
    WAIT_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic [3:0]             bit_cnt;
  logic [6:0]             addr_sr;
  logic [6:0]             tx_sr;
  logic                   phase;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] addr_next;

  // Input synchronizers plus one history stage; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign addr_next = {addr_sr, sda_s};

  // Protocol FSM; bus conditions override every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sda_out   <= 1'b1;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      acked     <= 1'b0;
      bit_cnt   <= 4'd0;
      addr_sr   <= 7'd0;
      tx_sr     <= 7'd0;
      phase     <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_out <= 1'b1;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
        phase   <= 1'b0;
      end else if (start_det) begin
        state   <= ADDR;
        sda_out <= 1'b1;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
        phase   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_out <= 1'b1;
            busy    <= 1'b0;
          end
          ADDR: begin
            if (scl_rise) begin
              addr_sr <= addr_next[6:0];
              if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                phase <= 1'b0;
                state <= (addr_next == {ADDRESS, 1'b1}) ? ADDR_ACK : WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_out <= 1'b0;
                busy    <= 1'b1;
                phase   <= 1'b1;
              end else begin
                tx_sr   <= joypad[6:0];
                sda_out <= joypad[7];
                bit_cnt <= 4'd0;
                state   <= TX;
              end
            end
          end
          TX: begin
            if (scl_rise) begin
              if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_out <= 1'b1;
                phase   <= 1'b0;
                state   <= MST_ACK;
              end else if (bit_cnt != 4'd0) begin
                sda_out <= tx_sr[6];
                tx_sr   <= {tx_sr[5:0], 1'b0};
              end
            end
          end
          MST_ACK: begin
            if (scl_rise && !phase) begin
              byte_done <= 1'b1;
              acked     <= ~sda_s;
              if (sda_s) state <= WAIT_STOP;
              else       phase <= 1'b1;
            end else if (scl_fall && phase) begin
              // Master asked for more: take a fresh snapshot for this byte.
              tx_sr   <= joypad[6:0];
              sda_out <= joypad[7];
              bit_cnt <= 4'd0;
              phase   <= 1'b0;
              state   <= TX;
            end
          end
          WAIT_STOP: begin
            sda_out <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            sda_out <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_target.sv
// Directed bench for nes_pad_target: a behavioural bus master drives scl/sda
// with 10-clk half periods against a wired-AND data line.
module tb_nes_pad_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       sda_out;
  logic [7:0] joypad;
  logic       busy;
  logic       byte_done;
  logic       acked;
  logic       sda_wire;

  int tests  = 0;
  int failed = 0;
  int bd_cnt = 0;
  int low_cnt = 0;
  int busy_cnt = 0;

  assign sda_wire = m_sda & sda_out;

  always #5 clk = ~clk;

  nes_pad_target #(.ADDRESS(7'h52), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (m_scl),
    .sda_in    (sda_wire),
    .sda_out   (sda_out),
    .joypad    (joypad),
    .busy      (busy),
    .byte_done (byte_done),
    .acked     (acked)
  );

  // Running event counters; tests compare deltas.
  always @(posedge clk) begin
    if (byte_done) bd_cnt <= bd_cnt + 1;
    if (!sda_out)  low_cnt <= low_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<2ms", $time);
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clk(5);
    m_scl = 1'b1; wait_clk(5);
    m_sda = 1'b0; wait_clk(5);
    m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(5); m_sda = 1'b0;
    wait_clk(5); m_scl = 1'b1;
    wait_clk(5); m_sda = 1'b1;
  endtask

  task automatic master_bit(input logic b, output logic rd);
    wait_clk(5); m_sda = b;
    wait_clk(5); m_scl = 1'b1;
    wait_clk(5); rd = sda_wire;
    wait_clk(5); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 0; i < 8; i++) master_bit(d[7-i], r);
    master_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, input int chg_bit, input logic [7:0] chg_val,
                           output logic [7:0] d);
    logic r;
    for (int i = 0; i < 8; i++) begin
      if (i == chg_bit) joypad = chg_val;
      master_bit(1'b1, r);
      d[7-i] = r;
    end
    master_bit(~mack, r);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; joypad = 8'hFF;
    wait_clk(3);
    tests++;
    if ({sda_out, busy, byte_done, acked} !== 4'b1000) begin
      failed++;
      $display("FAIL reset_outputs: got %b required 1000", {sda_out, busy, byte_done, acked});
    end
    rst = 1'b0;
    wait_clk(10);
  endtask

  task automatic test_read_nack();
    logic ack; logic [7:0] d; int bd0;
    joypad = 8'hA5; bd0 = bd_cnt;
    bus_start();
    write_byte(8'hA5, ack);
    tests++;
    if (ack !== 1'b1) begin failed++; $display("FAIL read_addr_ack: got %b required 1", ack); end
    tests++;
    if (busy !== 1'b1) begin failed++; $display("FAIL read_busy: got %b required 1", busy); end
    read_byte(1'b0, -1, 8'h00, d);
    tests++;
    if (d !== 8'hA5) begin failed++; $display("FAIL read_data: got %h required a5", d); end
    tests++;
    if (bd_cnt - bd0 != 1) begin failed++; $display("FAIL read_byte_done: got %0d required 1", bd_cnt - bd0); end
    tests++;
    if (acked !== 1'b0) begin failed++; $display("FAIL read_acked: got %b required 0", acked); end
    wait_clk(5); m_sda = 1'b0;
    wait_clk(5); m_scl = 1'b1;
    wait_clk(5); m_sda = 1'b1;
    wait_clk(2);
    tests++;
    if (busy !== 1'b1) begin failed++; $display("FAIL stop_busy_early: got %b required 1", busy); end
    wait_clk(1);
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL stop_busy_clear: got %b required 0", busy); end
    wait_clk(10);
  endtask

  task automatic test_addr_mismatch();
    logic ack; logic [7:0] d; int bd0, l0, b0;
    joypad = 8'h00; bd0 = bd_cnt; l0 = low_cnt; b0 = busy_cnt;
    bus_start();
    write_byte(8'hA7, ack);
    tests++;
    if (ack !== 1'b0) begin failed++; $display("FAIL mismatch_ack: got %b required 0", ack); end
    read_byte(1'b0, -1, 8'h00, d);
    tests++;
    if (d !== 8'hFF) begin failed++; $display("FAIL mismatch_data: got %h required ff", d); end
    bus_stop(); wait_clk(10);
    tests++;
    if (low_cnt != l0 || busy_cnt != b0 || bd_cnt != bd0) begin
      failed++;
      $display("FAIL mismatch_quiet: low=%0d busy=%0d done=%0d required 0 0 0",
               low_cnt - l0, busy_cnt - b0, bd_cnt - bd0);
    end
  endtask

  task automatic test_two_byte();
    logic ack; logic [7:0] d1, d2; int bd0;
    joypad = 8'hFF; bd0 = bd_cnt;
    bus_start();
    write_byte(8'hA5, ack);
    read_byte(1'b1, 3, 8'h00, d1);
    tests++;
    if (d1 !== 8'hFF) begin failed++; $display("FAIL two_byte1: got %h required ff", d1); end
    tests++;
    if (acked !== 1'b1 || bd_cnt - bd0 != 1) begin
      failed++; $display("FAIL two_ack1: acked=%b done=%0d required 1 1", acked, bd_cnt - bd0);
    end
    read_byte(1'b0, -1, 8'h00, d2);
    tests++;
    if (d2 !== 8'h00) begin failed++; $display("FAIL two_byte2: got %h required 00", d2); end
    tests++;
    if (acked !== 1'b0 || bd_cnt - bd0 != 2) begin
      failed++; $display("FAIL two_ack2: acked=%b done=%0d required 0 2", acked, bd_cnt - bd0);
    end
    bus_stop(); wait_clk(10);
  endtask

  task automatic test_write_ignored();
    logic ack; logic [7:0] d; int l0;
    l0 = low_cnt; joypad = 8'h5A;
    bus_start();
    write_byte(8'hA4, ack);
    tests++;
    if (ack !== 1'b0) begin failed++; $display("FAIL write_addr_ack: got %b required 0", ack); end
    write_byte(8'h00, ack);
    tests++;
    if (low_cnt != l0 || ack !== 1'b0) begin
      failed++; $display("FAIL write_quiet: low=%0d ack=%b required 0 0", low_cnt - l0, ack);
    end
    bus_stop(); wait_clk(10);
    bus_start();
    write_byte(8'hA5, ack);
    read_byte(1'b0, -1, 8'h00, d);
    tests++;
    if (ack !== 1'b1 || d !== 8'h5A) begin
      failed++; $display("FAIL write_then_read: ack=%b data=%h required 1 5a", ack, d);
    end
    bus_stop(); wait_clk(10);
  endtask

  task automatic test_restart();
    logic ack, r; logic [7:0] d; logic [3:0] hi;
    joypad = 8'h3C;
    bus_start();
    write_byte(8'hA5, ack);
    for (int i = 0; i < 4; i++) begin master_bit(1'b1, r); hi[3-i] = r; end
    tests++;
    if (hi !== 4'h3) begin failed++; $display("FAIL restart_bits: got %h required 3", hi); end
    joypad = 8'h96;
    wait_clk(5);
    m_sda = 1'b1; wait_clk(5);
    m_scl = 1'b1; wait_clk(5);
    m_sda = 1'b0; wait_clk(3);
    tests++;
    if (sda_out !== 1'b1 || busy !== 1'b0) begin
      failed++; $display("FAIL restart_release: sda_out=%b busy=%b required 1 0", sda_out, busy);
    end
    wait_clk(2); m_scl = 1'b0;
    write_byte(8'hA5, ack);
    read_byte(1'b0, -1, 8'h00, d);
    tests++;
    if (ack !== 1'b1 || d !== 8'h96) begin
      failed++; $display("FAIL restart_read: ack=%b data=%h required 1 96", ack, d);
    end
    bus_stop(); wait_clk(10);
  endtask

  task automatic test_reset_mid_ack();
    logic ack, r; logic [7:0] d; logic [7:0] a; int bd0;
    joypad = 8'hC3; bd0 = bd_cnt; a = 8'hA5;
    bus_start();
    for (int i = 0; i < 8; i++) master_bit(a[7-i], r);
    wait_clk(5);
    tests++;
    if (sda_out !== 1'b0 || busy !== 1'b1) begin
      failed++; $display("FAIL rst_pre_ack: sda_out=%b busy=%b required 0 1", sda_out, busy);
    end
    rst = 1'b1; wait_clk(1); rst = 1'b0;
    tests++;
    if (sda_out !== 1'b1 || busy !== 1'b0) begin
      failed++; $display("FAIL rst_release: sda_out=%b busy=%b required 1 0", sda_out, busy);
    end
    wait_clk(5); m_scl = 1'b1; wait_clk(10); m_scl = 1'b0;
    bus_stop(); wait_clk(10);
    tests++;
    if (bd_cnt != bd0) begin failed++; $display("FAIL rst_no_done: got %0d required 0", bd_cnt - bd0); end
    bus_start();
    write_byte(8'hA5, ack);
    read_byte(1'b0, -1, 8'h00, d);
    tests++;
    if (ack !== 1'b1 || d !== 8'hC3) begin
      failed++; $display("FAIL rst_recover: ack=%b data=%h required 1 c3", ack, d);
    end
    bus_stop(); wait_clk(10);
  endtask

  initial begin
    test_reset();
    test_read_nack();
    test_addr_mismatch();
    test_two_byte();
    test_write_ignored();
    test_restart();
    test_reset_mid_ack();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
